sum_accumulator: RTL and testbench

- Downstream stage of the N-bit ripple parallel adder.
- Consumes each {carry_out, sum} result under a valid/ready handshake and accumulates COUNT results into a wider register.
- Presents the frame total to the next stage with a valid/ready handshake and a sticky overflow flag.
- Used for multi-term sums built from repeated adder passes.

---
 rtl/sum_accumulator.sv | 107 ++++++++++
 tb/tb_sum_accumulator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates COUNT {carry, sum} adder results into an ACC_W-bit total and
// hands the frame total downstream under valid/ready with a sticky overflow flag.
module sum_accumulator #(
   parameter int N     = 4,
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     sum,
   input  logic             carry_in,
   input  logic             clear,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [ACC_W-1:0] acc_r, acc_s;
   logic             ovf_r, ovf_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             in_ready_r, out_valid_r;
   logic [ACC_W:0]   add_s;

   // Next-state, accumulator and counter update; clear overrides everything.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      ovf_s   = ovf_r;
      cnt_s   = cnt_r;
      add_s   = {1'b0, acc_r} + {{(ACC_W - N){1'b0}}, carry_in, sum};
      case (state_r)
         ACCUM: begin
            if (in_valid) begin
               acc_s = add_s[ACC_W-1:0];
               ovf_s = ovf_r | add_s[ACC_W];
               if (cnt_r == CNT_W'(COUNT - 1)) begin
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = HOLD;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               acc_s = acc_r;
            end
         end
         HOLD: begin
            if (out_ready) begin
               acc_s   = {ACC_W{1'b0}};
               ovf_s   = 1'b0;
               state_s = ACCUM;
            end else begin
               acc_s = acc_r;
            end
         end
         default: begin
            acc_s   = {ACC_W{1'b0}};
            ovf_s   = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
            state_s = ACCUM;
         end
      endcase
      if (clear) begin
         acc_s   = {ACC_W{1'b0}};
         ovf_s   = 1'b0;
         cnt_s   = {CNT_W{1'b0}};
         state_s = ACCUM;
      end else begin
         state_s = state_s;
      end
   end

   // State and output registers; handshake flags are decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ACCUM;
         acc_r       <= {ACC_W{1'b0}};
         ovf_r       <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         ovf_r       <= ovf_s;
         cnt_r       <= cnt_s;
         in_ready_r  <= (state_s == ACCUM);
         out_valid_r <= (state_s == HOLD);
      end
   end

   assign acc_out   = acc_r;
   assign overflow  = ovf_r;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized and directed bench for sum_accumulator; two instances (ACC_W=8
// and ACC_W=6) share stimulus and are checked against an arithmetic frame model.
module tb_sum_accumulator;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] sum;
   logic       carry_in;
   logic       clear;
   logic       out_ready;

   logic       in_ready8, out_valid8, overflow8;
   logic [7:0] acc8;
   logic       in_ready6, out_valid6, overflow6;
   logic [5:0] acc6;

   int n_checks;
   int n_fail;

   // model: true (unwrapped) frame sum, terms accepted, holding flag
   int m_sum;
   int m_cnt;
   bit m_hold;

   sum_accumulator #(.N(4), .ACC_W(8), .COUNT(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
      .sum(sum), .carry_in(carry_in), .clear(clear), .acc_out(acc8),
      .out_valid(out_valid8), .out_ready(out_ready), .overflow(overflow8)
   );

   sum_accumulator #(.N(4), .ACC_W(6), .COUNT(4)) dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
      .sum(sum), .carry_in(carry_in), .clear(clear), .acc_out(acc6),
      .out_valid(out_valid6), .out_ready(out_ready), .overflow(overflow6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check_eq("acc8",       {24'd0, acc8},      m_sum % 256);
      check_eq("ovf8",       {31'd0, overflow8}, (m_sum >= 256) ? 1 : 0);
      check_eq("valid8",     {31'd0, out_valid8}, m_hold ? 1 : 0);
      check_eq("ready8",     {31'd0, in_ready8},  m_hold ? 0 : 1);
      check_eq("acc6",       {26'd0, acc6},      m_sum % 64);
      check_eq("ovf6",       {31'd0, overflow6}, (m_sum >= 64) ? 1 : 0);
      check_eq("valid6",     {31'd0, out_valid6}, m_hold ? 1 : 0);
      check_eq("ready6",     {31'd0, in_ready6},  m_hold ? 0 : 1);
   endtask

   task automatic drive(input bit v, input bit c, input int s, input bit clr, input bit ordy);
      in_valid  = v;
      carry_in  = c;
      sum       = s[3:0];
      clear     = clr;
      out_ready = ordy;
   endtask

   // advance the model by one clock using the inputs now applied, then compare
   task automatic step();
      if (clear) begin
         m_sum = 0; m_cnt = 0; m_hold = 0;
      end else if (m_hold) begin
         if (out_ready) begin
            m_sum = 0; m_hold = 0;
         end
      end else if (in_valid) begin
         m_sum = m_sum + (carry_in ? 16 : 0) + int'(sum);
         m_cnt = m_cnt + 1;
         if (m_cnt == 4) begin
            m_cnt = 0; m_hold = 1;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   // asynchronous reset pulse between clock edges
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_acc8",   {24'd0, acc8}, 0);
      check_eq("rst_valid8", {31'd0, out_valid8}, 0);
      check_eq("rst_ovf8",   {31'd0, overflow8}, 0);
      check_eq("rst_acc6",   {26'd0, acc6}, 0);
      check_eq("rst_valid6", {31'd0, out_valid6}, 0);
      m_sum = 0; m_cnt = 0; m_hold = 0;
      #1 rst = 1'b0;
      #1;
      check_eq("rst_ready8", {31'd0, in_ready8}, 1);
      check_eq("rst_ready6", {31'd0, in_ready6}, 1);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      m_sum = 0; m_cnt = 0; m_hold = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 check_all();

      // basic frame: 3 + 5 + 18 + 15 = 41
      drive(1'b1, 1'b0, 3, 1'b0, 1'b0);  step();
      drive(1'b1, 1'b0, 5, 1'b0, 1'b0);  step();
      drive(1'b1, 1'b1, 2, 1'b0, 1'b0);  step();
      drive(1'b1, 1'b0, 15, 1'b0, 1'b0); step();
      check_eq("basic_total", {24'd0, acc8}, 32'h29);
      check_eq("basic_valid", {31'd0, out_valid8}, 1);

      // backpressure with in_valid held high
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 9, 1'b0, 1'b0); step();
      end
      check_eq("bp_hold", {24'd0, acc8}, 32'h29);
      drive(1'b1, 1'b1, 9, 1'b0, 1'b1); step();
      check_eq("bp_drain", {24'd0, acc8}, 0);

      // overflow: four 31-terms, 124 wraps to 60 in 6 bits
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 15, 1'b0, 1'b0); step();
      end
      check_eq("ovf_total6", {26'd0, acc6}, 60);
      check_eq("ovf_flag6", {31'd0, overflow6}, 1);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b1); step();
      check_eq("ovf_cleared6", {31'd0, overflow6}, 0);

      // clear mid-frame beats a simultaneous accept
      drive(1'b1, 1'b0, 7, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 9, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 4, 1'b1, 1'b0); step();
      check_eq("clr_acc", {24'd0, acc8}, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1, 1'b0, 1'b0); step();
      end
      check_eq("clr_total", {24'd0, acc8}, 4);
      check_eq("clr_valid", {31'd0, out_valid8}, 1);

      // async reset while holding, then a fresh frame of 2s
      async_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 2, 1'b0, 1'b0); step();
      end
      check_eq("post_rst_total", {24'd0, acc8}, 8);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b1); step();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 2) != 0));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
